// File: rtl/alu_operand_pkg.sv
// Shared select codes and widths for the ALU-B operand stage.
package alu_operand_pkg;

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_SRC0     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_CONST    = 3'b001;
    localparam logic [SEL_W-1:0] SEL_SRC1     = 3'b010;
    localparam logic [SEL_W-1:0] SEL_SRC2     = 3'b011;
    localparam logic [SEL_W-1:0] SEL_SEXT     = 3'b100;
    localparam logic [SEL_W-1:0] SEL_SEXT_SH2 = 3'b101;
    localparam logic [SEL_W-1:0] SEL_ZEXT     = 3'b110;
    localparam logic [SEL_W-1:0] SEL_ILLEGAL  = 3'b111;

endpackage

// File: rtl/alu_operand_stage_select.sv
// Combinational operand mux: register sources, constant and extended immediates.
module operand_select
    import alu_operand_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic [SEL_W-1:0]  selector,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] value,
    output logic              illegal
);

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_sext_sh2;
    logic [DATA_W-1:0] imm_zext;

    always_comb begin
        imm_sext     = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        // Shift happens on the full-width value; top two bits fall off.
        imm_sext_sh2 = {imm_sext[DATA_W-3:0], 2'b00};
        imm_zext     = {{(DATA_W-IMM_W){1'b0}}, imm};
    end

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (selector)
            SEL_SRC0:     value = data_0;
            SEL_CONST:    value = DATA_W'(CONST_VAL);
            SEL_SRC1:     value = data_1;
            SEL_SRC2:     value = data_2;
            SEL_SEXT:     value = imm_sext;
            SEL_SEXT_SH2: value = imm_sext_sh2;
            SEL_ZEXT:     value = imm_zext;
            default: begin
                value   = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU-B operand stage: one-entry valid/ready register with flush
// and sticky/saturating illegal-select reporting.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned CONST_VAL = 4,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          selector,
    input  logic [DATA_W-1:0]   data_0,
    input  logic [DATA_W-1:0]   data_1,
    input  logic [DATA_W-1:0]   data_2,
    input  logic [IMM_W-1:0]    imm,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [DATA_W-1:0]   data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sel_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic [DATA_W-1:0]   sel_value;
    logic                sel_illegal;
    logic                accept;

    logic [DATA_W-1:0]   data_out_d,  data_out_q;
    logic                out_valid_d, out_valid_q;
    logic                sel_err_d,   sel_err_q;
    logic [ERRCNT_W-1:0] err_count_d, err_count_q;

    operand_select #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .CONST_VAL (CONST_VAL)
    ) u_select (
        .selector (selector),
        .data_0   (data_0),
        .data_1   (data_1),
        .data_2   (data_2),
        .imm      (imm),
        .value    (sel_value),
        .illegal  (sel_illegal)
    );

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready && !flush;
    end

    // Flush wins over accept and drain; it never touches data or error state.
    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        err_count_d = err_count_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            data_out_d  = sel_value;
            out_valid_d = 1'b1;
            if (sel_illegal) begin
                sel_err_d = 1'b1;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + 1'b1;
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        data_out  = data_out_q;
        out_valid = out_valid_q;
        sel_err   = sel_err_q;
        err_count = err_count_q;
    end

endmodule
